// File: rtl/win_scanner.sv
// Scans the four axes through the freshly dropped piece via a 1-cycle-latency board read port.
// Latency: 2 cycles per in-bounds probe, 1 per out-of-bounds ray end, +1 FINISH; start ignored unless IDLE.
module win_scanner #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4,
  parameter int ROW_W   = 3,
  parameter int COL_W   = 3,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ROW_W-1:0] origin_row,
  input  logic [COL_W-1:0] origin_col,
  input  logic             player,
  output logic             rd_en,
  output logic [ROW_W-1:0] rd_row,
  output logic [COL_W-1:0] rd_col,
  input  logic [1:0]       rd_data,
  output logic             busy,
  output logic             done,
  output logic             win,
  output logic [1:0]       win_axis,
  output logic [CNT_W-1:0] win_count
);

  localparam int SW = ((ROW_W > COL_W) ? ROW_W : COL_W) + CNT_W + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, FINISH} state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] org_row_q, org_row_d, rd_row_q;
  logic [COL_W-1:0] org_col_q, org_col_d, rd_col_q;
  logic             player_q, player_d;
  logic [1:0]       axis_q, axis_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] step_q, step_d, count_q, count_d;
  logic             win_q, win_d;
  logic [1:0]       win_axis_q, win_axis_d;
  logic [CNT_W-1:0] win_count_q, win_count_d;

  logic signed [SW-1:0] step_s, off_r, off_c, tgt_row, tgt_col;
  logic                 in_bounds, ray_end, origin_oor;

  // Target cell = origin + step * axis vector; the negative ray flips the vector.
  always_comb begin
    step_s = $signed({{(SW-CNT_W){1'b0}}, step_q});
    off_r  = '0;
    off_c  = '0;
    case (axis_q)
      2'd0:    off_r = step_s;
      2'd1:    off_c = step_s;
      2'd2:    begin off_r = step_s;  off_c = step_s; end
      default: begin off_r = -step_s; off_c = step_s; end
    endcase
    if (neg_q) begin
      off_r = -off_r;
      off_c = -off_c;
    end
    tgt_row   = $signed({{(SW-ROW_W){1'b0}}, org_row_q}) + off_r;
    tgt_col   = $signed({{(SW-COL_W){1'b0}}, org_col_q}) + off_c;
    in_bounds = !tgt_row[SW-1] && (tgt_row < $signed(SW'(ROWS))) &&
                !tgt_col[SW-1] && (tgt_col < $signed(SW'(COLS)));
  end

  assign origin_oor = ({1'b0, origin_row} >= (ROW_W+1)'(ROWS)) ||
                      ({1'b0, origin_col} >= (COL_W+1)'(COLS));

  always_comb begin
    state_d     = state_q;
    org_row_d   = org_row_q;
    org_col_d   = org_col_q;
    player_d    = player_q;
    axis_d      = axis_q;
    neg_d       = neg_q;
    step_d      = step_q;
    count_d     = count_q;
    win_d       = win_q;
    win_axis_d  = win_axis_q;
    win_count_d = win_count_q;
    ray_end     = 1'b0;
    rd_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          org_row_d   = origin_row;
          org_col_d   = origin_col;
          player_d    = player;
          axis_d      = 2'd0;
          neg_d       = 1'b0;
          step_d      = CNT_W'(1);
          count_d     = CNT_W'(1);
          win_d       = 1'b0;
          win_axis_d  = 2'd0;
          win_count_d = '0;
          state_d     = origin_oor ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        if (in_bounds) begin
          rd_en   = 1'b1;
          state_d = CHECK;
        end else begin
          ray_end = 1'b1;
        end
      end
      CHECK: begin
        if (rd_data == {player_q, ~player_q}) begin
          count_d = count_q + CNT_W'(1);
          if (count_d == CNT_W'(WIN_LEN)) begin
            win_d       = 1'b1;
            win_axis_d  = axis_q;
            win_count_d = CNT_W'(WIN_LEN);
            state_d     = FINISH;
          end else if (step_q == CNT_W'(WIN_LEN-1)) begin
            ray_end = 1'b1;
          end else begin
            step_d  = step_q + CNT_W'(1);
            state_d = ISSUE;
          end
        end else begin
          ray_end = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The + ray hands its count to the - ray; the axis total is folded in after the - ray.
    if (ray_end) begin
      step_d = CNT_W'(1);
      if (!neg_q) begin
        neg_d   = 1'b1;
        state_d = ISSUE;
      end else begin
        if (count_d > win_count_d) win_count_d = count_d;
        neg_d   = 1'b0;
        count_d = CNT_W'(1);
        if (axis_q == 2'd3) begin
          state_d = FINISH;
        end else begin
          axis_d  = axis_q + 2'd1;
          state_d = ISSUE;
        end
      end
    end
  end

  assign rd_row    = rd_en ? tgt_row[ROW_W-1:0] : rd_row_q;
  assign rd_col    = rd_en ? tgt_col[COL_W-1:0] : rd_col_q;
  assign busy      = (state_q == ISSUE) || (state_q == CHECK);
  assign done      = (state_q == FINISH);
  assign win       = win_q;
  assign win_axis  = win_axis_q;
  assign win_count = win_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      org_row_q   <= '0;
      org_col_q   <= '0;
      player_q    <= 1'b0;
      axis_q      <= 2'd0;
      neg_q       <= 1'b0;
      step_q      <= '0;
      count_q     <= '0;
      win_q       <= 1'b0;
      win_axis_q  <= 2'd0;
      win_count_q <= '0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
    end else begin
      state_q     <= state_d;
      org_row_q   <= org_row_d;
      org_col_q   <= org_col_d;
      player_q    <= player_d;
      axis_q      <= axis_d;
      neg_q       <= neg_d;
      step_q      <= step_d;
      count_q     <= count_d;
      win_q       <= win_d;
      win_axis_q  <= win_axis_d;
      win_count_q <= win_count_d;
      rd_row_q    <= rd_row;
      rd_col_q    <= rd_col;
    end
  end

endmodule

// File: tb/tb_win_scanner.sv
// Directed bench: default 6x7/WIN_LEN=4 instance plus an 8x8/WIN_LEN=5 instance, each with a board model.
module tb_win_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, sel, plyr;
  logic [2:0] o_row, o_col;

  logic       rd_en1, busy1, done1, win1, rd_en2, busy2, done2, win2;
  logic [2:0] rd_row1, rd_col1, wcnt1, rd_row2, rd_col2, wcnt2;
  logic [1:0] rd_data1, rd_data2, wax1, wax2;

  win_scanner u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .origin_row(o_row), .origin_col(o_col),
    .player(plyr), .rd_en(rd_en1), .rd_row(rd_row1), .rd_col(rd_col1), .rd_data(rd_data1),
    .busy(busy1), .done(done1), .win(win1), .win_axis(wax1), .win_count(wcnt1)
  );

  win_scanner #(.ROWS(8), .COLS(8), .WIN_LEN(5), .ROW_W(3), .COL_W(3), .CNT_W(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .origin_row(o_row), .origin_col(o_col),
    .player(plyr), .rd_en(rd_en2), .rd_row(rd_row2), .rd_col(rd_col2), .rd_data(rd_data2),
    .busy(busy2), .done(done2), .win(win2), .win_axis(wax2), .win_count(wcnt2)
  );

  logic [1:0] b1 [0:7][0:7];
  logic [1:0] b2 [0:7][0:7];

  always @(posedge clk) begin
    rd_data1 <= b1[rd_row1][rd_col1];
    rd_data2 <= b2[rd_row2][rd_col2];
  end

  logic       m_rd_en, m_busy, m_done, m_win;
  logic [2:0] m_rd_row, m_rd_col, m_cnt;
  logic [1:0] m_ax;
  assign m_rd_en  = sel ? rd_en2  : rd_en1;
  assign m_rd_row = sel ? rd_row2 : rd_row1;
  assign m_rd_col = sel ? rd_col2 : rd_col1;
  assign m_busy   = sel ? busy2   : busy1;
  assign m_done   = sel ? done2   : done1;
  assign m_win    = sel ? win2    : win1;
  assign m_ax     = sel ? wax2    : wax1;
  assign m_cnt    = sel ? wcnt2   : wcnt1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic put(input int r, input int c, input logic [1:0] v);
    b1[r][c] = v;
    b2[r][c] = v;
  endtask

  // Both board models always hold the same pattern.
  task automatic set_board(input int id);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) put(r, c, 2'b00);
    case (id)
      1: for (int r = 0; r < 4; r++) put(r, 2, 2'b01);
      2: for (int c = 1; c < 5; c++) put(0, c, 2'b10);
      3: begin put(3, 0, 2'b01); put(2, 1, 2'b01); put(1, 2, 2'b01); put(0, 3, 2'b01); end
      4: begin put(3, 0, 2'b01); put(2, 1, 2'b01); put(1, 2, 2'b01); put(0, 3, 2'b10); end
      5: for (int c = 0; c < 5; c++) put(0, c, 2'b10);
      6: for (int c = 0; c < 4; c++) put(0, c, 2'b01);
      7: begin for (int r = 0; r < 4; r++) put(r, 2, 2'b01); put(1, 2, 2'b11); end
      default: ;
    endcase
  endtask

  int         r_cyc, r_nrd, r_extra, r_busy_done, r_lr, r_lc, r_win_end;
  logic       r_win;
  logic [1:0] r_ax;
  logic [2:0] r_cnt;
  int         log_r [0:31];
  int         log_c [0:31];

  // Samples 1 ns after each edge; cycle 1 is the cycle following the start edge.
  task automatic run(input int s, input int r, input int c, input int p, input int inj);
    @(negedge clk);
    sel = s[0]; o_row = r[2:0]; o_col = c[2:0]; plyr = p[0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    r_cyc = -1; r_nrd = 0; r_extra = 0; r_busy_done = -1; r_win_end = -1;
    for (int n = 1; n <= 300; n++) begin
      if (inj != 0 && n == inj) begin start = 1'b1; o_row = 3'd6; o_col = 3'd0; end
      if (inj != 0 && n == inj + 1) start = 1'b0;
      if (m_rd_en) begin
        if (r_nrd < 32) begin log_r[r_nrd] = int'(m_rd_row); log_c[r_nrd] = int'(m_rd_col); end
        r_nrd++;
      end
      if (m_done) begin
        if (r_cyc < 0) begin
          r_cyc = n; r_win = m_win; r_ax = m_ax; r_cnt = m_cnt;
          r_busy_done = int'(m_busy); r_lr = int'(m_rd_row); r_lc = int'(m_rd_col);
        end else r_extra++;
      end
      if (r_cyc > 0 && n >= r_cyc + 4) begin
        r_win_end = int'(m_win);
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  typedef struct {
    int s; int bid; int r; int c; int p; int inj;
    int cyc; int nrd; int w; int ax; int cnt;
  } vec_t;

  vec_t vt [0:9];

  initial begin
    vt[0] = '{0, 1, 3, 2, 0, 0,  9, 4, 1, 0, 4}; // vertical
    vt[1] = '{0, 2, 0, 3, 1, 0, 12, 5, 1, 1, 4}; // horizontal, origin mid-run
    vt[2] = '{0, 0, 0, 0, 0, 0, 12, 3, 0, 0, 1}; // corner, lone piece
    vt[3] = '{0, 3, 1, 2, 0, 0, 20, 9, 1, 3, 4}; // diag down-right
    vt[4] = '{0, 4, 1, 2, 0, 0, 20, 9, 0, 0, 3}; // diag blocked by opponent
    vt[5] = '{0, 0, 6, 0, 0, 0,  1, 0, 0, 0, 0}; // origin row out of range
    vt[6] = '{0, 7, 3, 2, 0, 0, 19, 9, 0, 0, 2}; // invalid cell breaks ray
    vt[7] = '{0, 1, 3, 2, 0, 3,  9, 4, 1, 0, 4}; // start while busy ignored
    vt[8] = '{1, 5, 0, 2, 1, 0, 14, 6, 1, 1, 5}; // 8x8 run of 5
    vt[9] = '{1, 6, 0, 3, 0, 0, 19, 7, 0, 0, 4}; // 8x8 run of 4

    rst_n = 1'b0; start = 1'b0; sel = 1'b0; plyr = 1'b0; o_row = '0; o_col = '0;
    set_board(0);
    #1;
    chk("reset_outs_dut1", int'({busy1, done1, rd_en1, win1, wax1, rd_row1, rd_col1, wcnt1}), 0);
    chk("reset_outs_dut2", int'({busy2, done2, rd_en2, win2, wax2, rd_row2, rd_col2, wcnt2}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++) begin
      set_board(vt[i].bid);
      run(vt[i].s, vt[i].r, vt[i].c, vt[i].p, vt[i].inj);
      chk($sformatf("v%0d_done_cycle", i), r_cyc, vt[i].cyc);
      chk($sformatf("v%0d_reads", i), r_nrd, vt[i].nrd);
      chk($sformatf("v%0d_win", i), int'(r_win), vt[i].w);
      chk($sformatf("v%0d_axis", i), int'(r_ax), vt[i].ax);
      chk($sformatf("v%0d_count", i), int'(r_cnt), vt[i].cnt);
      chk($sformatf("v%0d_extra_done", i), r_extra, 0);
      chk($sformatf("v%0d_busy_at_done", i), r_busy_done, 0);
      chk($sformatf("v%0d_win_held", i), r_win_end, vt[i].w);
      if (i == 0) begin
        chk("vert_last_rd_row_held", r_lr, 0);
        chk("vert_last_rd_col_held", r_lc, 2);
      end
      if (i == 2) begin
        chk("corner_rd0", log_r[0] * 8 + log_c[0], 1 * 8 + 0);
        chk("corner_rd1", log_r[1] * 8 + log_c[1], 0 * 8 + 1);
        chk("corner_rd2", log_r[2] * 8 + log_c[2], 1 * 8 + 1);
      end
    end

    // Reset in the middle of a scan, then a clean rescan.
    set_board(1);
    @(negedge clk);
    sel = 1'b0; o_row = 3'd3; o_col = 3'd2; plyr = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midscan_busy", int'(busy1), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midscan_reset_outs", int'({busy1, done1, rd_en1, win1, wax1, rd_row1, rd_col1, wcnt1}), 0);
    begin
      int dcount = 0;
      for (int n = 0; n < 12; n++) begin
        @(posedge clk); #1;
        if (done1) dcount++;
        if (n == 1) rst_n = 1'b1;
      end
      chk("midscan_no_done", dcount, 0);
    end
    run(0, 3, 2, 0, 0);
    chk("post_reset_done_cycle", r_cyc, 9);
    chk("post_reset_win", int'(r_win), 1);
    chk("post_reset_count", int'(r_cnt), 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/win_scanner.md
Name: win_scanner

Overview:
- Sequential, parametrised successor to the combinational direction-bounds checker.
- After a piece lands at (row, col), it walks the board through a one-cycle-latency read port and counts consecutive same-colour pieces along the four axes: vertical, horizontal, diagonal up-right and diagonal down-right.
- It reports a win once any axis run reaches WIN_LEN.
- It sits between the drop controller (start/done handshake) and the board state memory (read port).

Parameters:
- ROWS, 6, board rows; row 0 is the bottom row.
- COLS, 7, board columns; column 0 is the leftmost column.
- WIN_LEN, 4, run length that counts as a win; must be >= 2.
- ROW_W, 3, row index width; must be >= $clog2(ROWS).
- COL_W, 3, column index width; must be >= $clog2(COLS).
- CNT_W, 3, run counter width; must be >= $clog2(WIN_LEN+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  one-cycle request to scan from the origin; sampled only in IDLE
- origin_row  in  ROW_W  row of the dropped piece; latched on start
- origin_col  in  COL_W  column of the dropped piece; latched on start
- player  in  1  colour of the dropped piece (0 or 1); latched on start
- rd_en  out  1  board read strobe
- rd_row  out  ROW_W  board read row
- rd_col  out  COL_W  board read column
- rd_data  in  2  cell contents, valid the cycle after rd_en: 00 empty, 01 player0, 10 player1, 11 invalid
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse: result valid
- win  out  1  result: run >= WIN_LEN found; held until next start
- win_axis  out  2  winning axis: 0 vertical, 1 horizontal, 2 diag up-right, 3 diag down-right; held
- win_count  out  CNT_W  best run found, capped at WIN_LEN; held

Behaviour:
- Reset values: all outputs 0; FSM returns to IDLE. Reset mid-scan aborts the scan with no done pulse.
- FSM states: IDLE, ISSUE, CHECK, FINISH.
- IDLE:
  - On start: latch the origin and player; set axis=0, ray=+, step=1, count=1.
  - Clear win, win_axis and win_count. Go to ISSUE.
  - If the origin is out of range (row>=ROWS or col>=COLS), go directly to FINISH with win=0 and issue no reads.
- Axis step vectors (dr, dc): axis0 (+1,0); axis1 (0,+1); axis2 (+1,+1); axis3 (-1,+1). The negative ray uses the negated vector.
- Target cell = origin + step*vector, with signed arithmetic.
- ISSUE:
  - Target out of bounds: end the ray in this cycle (1 cycle) and do not assert rd_en.
  - Target in bounds: assert rd_en with rd_row/rd_col set to the target, then go to CHECK.
- CHECK: rd_data is compared with {player, ~player}, i.e. 01 for player0 and 10 for player1.
  - Match: count+1. If count reaches WIN_LEN, set win=1, win_axis=axis, win_count=WIN_LEN and go to FINISH (early exit).
  - Match with step = WIN_LEN-1: the ray ends.
  - Otherwise, on a match: step+1, back to ISSUE.
  - Mismatch (empty, opponent or 11): the ray ends.
- Ray end:
  - After the + ray: switch to the - ray with step=1, keeping count.
  - After the - ray: win_count = max(win_count, count); then next axis with count=1.
  - After axis3: go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 in that cycle, then return to IDLE.
- busy = 1 in ISSUE and CHECK only.
- start during busy or FINISH is ignored. A start in the IDLE cycle after FINISH is accepted.
- Cost model: each in-bounds probe takes 2 cycles, each out-of-bounds ray end takes 1 cycle, and FINISH takes 1 cycle.
- rd_row/rd_col hold their last value when rd_en=0.

Test Plan:
- Vertical win: column 2 rows 0..3 = player0, origin (3,2), player=0.
  - Probes: row 4 (empty), then rows 2, 1, 0.
  - done exactly 9 cycles after the start edge; win=1, win_axis=0, win_count=4; exactly 4 rd_en pulses.
- Horizontal win with origin in the middle: row 0 cols 1..4 = player1, origin (0,3), player=1.
  - Axis0 ends on an empty cell; axis1 + ray matches col 4, then col 5 is empty; - ray matches cols 2, 1.
  - Required: win=1, win_axis=1, win_count=4.
- Corner origin (0,0), lone piece, empty board.
  - Every - ray ends out of bounds with no rd_en; win=0, win_count=1.
  - Exactly 3 reads: (1,0), (0,1), (1,1).
- Diagonal down-right win: cells (3,0), (2,1), (1,2), (0,3) = player0, origin (1,2).
  - Required: win_axis=3, win=1.
  - Opponent piece at (0,3) instead: win=0, win_count=3.
- Handshake and reset:
  - start pulsed while busy: ignored, single done.
  - Origin (6,0) with ROWS=6: done 1 cycle after start, win=0, no reads.
  - rst_n low mid-scan: all outputs 0 immediately, no done; a subsequent start completes normally.
- Parameter sweep: ROWS=8, COLS=8, WIN_LEN=5, ROW_W=3, COL_W=3.
  - Horizontal run of 5: win=1.
  - Run of 4: win=0, win_count=4.
